branch_issue_queue: RTL and testbench
=====================================

BRANCH_ISSUE_QUEUE -- requirements
Module: branch_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-002 SHALL have parameter NUM_CDB, default 2, number of CDB broadcast ports, >= 1.
REQ-003 SHALL have parameter PTR_W, default $clog2(DEPTH)+1, pointer width including one wrap bit.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous squash of all contents.
REQ-007 SHALL have port cdb_entry  input  cdb_entry_t[NUM_CDB]  wakeup broadcasts (valid, pd).
REQ-008 SHALL have port enq_valid  input  1  dispatch offers an entry.
REQ-009 SHALL have port enq_entry  input  rename_data_t  entry offered (ps1, ps2, ps1_v, ps2_v, valid, ...).
REQ-010 SHALL have port enq_ready  output  1  queue accepts an entry this cycle.
REQ-011 SHALL have port issue_valid  output  1  head entry ready to issue.
REQ-012 SHALL have port issue_ready  input  1  branch unit accepts head.
REQ-013 SHALL have port issue_entry  output  rename_data_t  head entry, zero when issue_valid=0.
REQ-014 SHALL have port count  output  PTR_W  occupied entries, 0..DEPTH.
REQ-015 SHALL have ports is_empty, is_full  output  1 each  count==0, count==DEPTH.

Function
REQ-016 SHALL implement in-order circular buffer; head/tail PTR_W bits, low PTR_W-1 bits index storage, MSB is wrap bit.
REQ-017 SHALL define empty as head==tail; full as equal index bits with differing wrap bits; count = tail-head modulo 2^PTR_W.
REQ-018 SHALL drive enq_ready = !is_full && !flush; enqueue fires on enq_valid && enq_ready, writes tail slot, tail+1 next edge.
REQ-019 SHALL drive issue_valid = !is_empty && !flush && head.valid && head.ps1_v && head.ps2_v; issue is combinational from registered head (zero-cycle latency).
REQ-020 SHALL fire issue on issue_valid && issue_ready; head+1 next edge; head entry's valid bit cleared.
REQ-021 SHALL hold head and entry when issue_valid && !issue_ready (no drop, stable issue_entry).
REQ-022 SHALL allow enqueue and issue in the same cycle; count unchanged; when full, enq_ready=0 regardless of issue_ready (no pass-through).
REQ-023 SHALL, for every stored entry and every CDB port k, set ps1_v (ps2_v) when cdb_entry[k].valid and cdb_entry[k].pd==ps1 (ps2) and pd!=0; multiple matching ports OR together.
REQ-024 SHALL never clear a ps*_v bit except by overwrite on enqueue, flush or reset.
REQ-025 SHALL handle pointer wrap from DEPTH-1 to 0 with wrap-bit toggle, no lost or duplicated entries.
REQ-026 SHALL, on flush, next edge set head=tail=0 and clear every entry's valid, ps1_v, ps2_v; flush overrides concurrent enqueue and issue (both suppressed that cycle).

Reset
REQ-027 SHALL, on rst asserted, immediately clear head, tail and all entries to zero, independent of clk.
REQ-028 SHALL present after reset: enq_ready=1, issue_valid=0, issue_entry=0, count=0, is_empty=1, is_full=0.
REQ-029 SHALL abandon any in-flight enqueue/issue when rst asserts mid-operation; first edge after deassert behaves as empty queue.

Configuration
REQ-030 SHALL honour macro BRQ_CDB_BYPASS_EN; when defined, an entry enqueued in the same cycle as a matching CDB broadcast is stored with the corresponding ps*_v already set.
REQ-031 SHALL, without BRQ_CDB_BYPASS_EN, store enq_entry ps*_v bits unmodified; same-cycle broadcast to the incoming entry is missed (dispatch must forward).

Verification
REQ-032 SHALL pass: reset, enqueue entry ps1=5 ps2=7 both not ready, cdb[0] pd=5 then cdb[1] pd=7 on later cycles -> issue_valid rises one cycle after second broadcast, issue_entry.ps1=5.
REQ-033 SHALL pass: enqueue 16 ready entries, issue_ready=0 -> is_full=1, count=16, enq_ready=0; then issue_ready=1 one cycle -> count=15, enq_ready=1.
REQ-034 SHALL pass: 40 enqueues interleaved with issues (count kept 1..16) -> issue order equals enqueue order across wrap, no drop.
REQ-035 SHALL pass: broadcast pd=0 valid=1 with entries ps1=0 unready -> ps1_v stays 0.
REQ-036 SHALL pass: 6 entries stored, flush with simultaneous enq_valid and issue_ready -> next cycle count=0, is_empty=1, nothing issued or stored.
REQ-037 SHALL pass: enqueue ps1=9 unready while cdb[1] pd=9 valid same cycle -> with BRQ_CDB_BYPASS_EN issue_valid=1 next cycle; without, issue_valid stays 0.

Source files
------------

// File: rtl/branch_issue_queue.sv
// In-order branch issue queue: a circular buffer whose entries wake up from CDB broadcasts.
// Optional macro BRQ_CDB_BYPASS_EN captures a same-cycle broadcast into the entry being enqueued.

package branch_issue_queue_pkg;
  localparam int PREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] pd;
  } cdb_entry_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic              ps1_v;
    logic [PREG_W-1:0] ps2;
    logic              ps2_v;
    logic [3:0]        br_mask;
    logic [3:0]        op;
    logic [31:0]       pc;
  } rename_data_t;
endpackage

module branch_issue_queue
  import branch_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2,
  parameter int PTR_W   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  cdb_entry_t           cdb_entry [NUM_CDB],
  input  logic                 enq_valid,
  input  rename_data_t         enq_entry,
  output logic                 enq_ready,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output rename_data_t         issue_entry,
  output logic [PTR_W-1:0]     count,
  output logic                 is_empty,
  output logic                 is_full
);

  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  rename_data_t     r_mem [DEPTH];

  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  rename_data_t     w_head_entry;
  rename_data_t     w_enq_data;
  logic [DEPTH-1:0] w_wake_ps1;
  logic [DEPTH-1:0] w_wake_ps2;
  logic             w_enq_fire;
  logic             w_issue_fire;

  assign w_head_idx   = r_head[IDX_W-1:0];
  assign w_tail_idx   = r_tail[IDX_W-1:0];
  assign w_head_entry = r_mem[w_head_idx];

  assign is_empty = (r_head == r_tail);
  assign is_full  = (w_head_idx == w_tail_idx) && (r_head[PTR_W-1] != r_tail[PTR_W-1]);
  assign count    = r_tail - r_head;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Ready never depends on the partner's valid; flush withdraws both sides for that cycle.
  assign enq_ready   = !is_full && !flush;
  assign issue_valid = !is_empty && !flush && w_head_entry.valid &&
                       w_head_entry.ps1_v && w_head_entry.ps2_v;
  assign issue_entry = issue_valid ? w_head_entry : '0;

  assign w_enq_fire   = enq_valid && enq_ready;
  assign w_issue_fire = issue_valid && issue_ready;

  // Physical register 0 is the hardwired zero register and never signals a wakeup.
  always_comb begin
    w_wake_ps1 = '0;
    w_wake_ps2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (cdb_entry[k].valid && (cdb_entry[k].pd != '0)) begin
          if (cdb_entry[k].pd == r_mem[i].ps1) w_wake_ps1[i] = 1'b1;
          if (cdb_entry[k].pd == r_mem[i].ps2) w_wake_ps2[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_enq_data = enq_entry;
`ifdef BRQ_CDB_BYPASS_EN
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_entry[k].valid && (cdb_entry[k].pd != '0)) begin
        if (cdb_entry[k].pd == enq_entry.ps1) w_enq_data.ps1_v = 1'b1;
        if (cdb_entry[k].pd == enq_entry.ps2) w_enq_data.ps2_v = 1'b1;
      end
    end
`endif
  end

  // Later non-blocking writes win: an enqueue overwrites any wakeup landing on the tail slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wake_ps1[i]) r_mem[i].ps1_v <= 1'b1;
        if (w_wake_ps2[i]) r_mem[i].ps2_v <= 1'b1;
      end
      if (w_issue_fire) begin
        r_mem[w_head_idx].valid <= 1'b0;
        r_head                  <= r_head + PTR_ONE;
      end
      if (w_enq_fire) begin
        r_mem[w_tail_idx] <= w_enq_data;
        r_tail            <= r_tail + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue: wakeup, full/empty, wrap ordering, flush, bypass, reset.

module tb_branch_issue_queue;
  import branch_issue_queue_pkg::*;

  localparam int DEPTH   = 16;
  localparam int NUM_CDB = 2;
  localparam int PTR_W   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush;
  cdb_entry_t       cdb_entry [NUM_CDB];
  logic             enq_valid;
  rename_data_t     enq_entry;
  logic             enq_ready;
  logic             issue_valid;
  logic             issue_ready;
  rename_data_t     issue_entry;
  logic [PTR_W-1:0] count;
  logic             is_empty;
  logic             is_full;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;

  branch_issue_queue #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .PTR_W(PTR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .cdb_entry   (cdb_entry),
    .enq_valid   (enq_valid),
    .enq_entry   (enq_entry),
    .enq_ready   (enq_ready),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_entry (issue_entry),
    .count       (count),
    .is_empty    (is_empty),
    .is_full     (is_full)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  function automatic rename_data_t mk(input logic [5:0] ps1, input logic [5:0] ps2,
                                      input logic v1, input logic v2, input logic [31:0] pc);
    rename_data_t e;
    e       = '0;
    e.valid = 1'b1;
    e.pd    = 6'd33;
    e.ps1   = ps1;
    e.ps2   = ps2;
    e.ps1_v = v1;
    e.ps2_v = v2;
    e.pc    = pc;
    return e;
  endfunction

  task automatic clear_in();
    flush       = 1'b0;
    enq_valid   = 1'b0;
    issue_ready = 1'b0;
    enq_entry   = '0;
    for (int k = 0; k < NUM_CDB; k++) cdb_entry[k] = '0;
  endtask

  task automatic bcast(input int k, input logic [5:0] pd);
    cdb_entry[k].valid = 1'b1;
    cdb_entry[k].pd    = pd;
  endtask

  task automatic enq_one(input rename_data_t e);
    enq_entry = e;
    enq_valid = 1'b1;
    tick();
    clear_in();
    #1;
  endtask

  task automatic issue_one();
    issue_ready = 1'b1;
    tick();
    clear_in();
    #1;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_enq_ready",   64'(enq_ready),   64'd1);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_entry", 64'(issue_entry), 64'd0);
    check("rst_count",       64'(count),       64'd0);
    check("rst_is_empty",    64'(is_empty),    64'd1);
    check("rst_is_full",     64'(is_full),     64'd0);

    // Wakeup through two separate broadcasts
    enq_one(mk(6'd5, 6'd7, 1'b0, 1'b0, 32'h100));
    check("wk_count1",  64'(count),       64'd1);
    check("wk_notrdy",  64'(issue_valid), 64'd0);
    bcast(0, 6'd5);
    tick(); clear_in(); #1;
    check("wk_half",    64'(issue_valid), 64'd0);
    bcast(1, 6'd7);
    tick(); clear_in(); #1;
    check("wk_ready",   64'(issue_valid),     64'd1);
    check("wk_ps1",     64'(issue_entry.ps1), 64'd5);
    check("wk_pc",      64'(issue_entry.pc),  64'h100);
    issue_one();
    check("wk_drained", 64'(is_empty),    64'd1);
    check("wk_zero",    64'(issue_entry), 64'd0);

    // Non-matching pd does nothing; two ports in one cycle OR together
    enq_one(mk(6'd12, 6'd13, 1'b0, 1'b0, 32'h200));
    bcast(0, 6'd14);
    tick(); clear_in(); #1;
    check("dual_nomatch", 64'(issue_valid), 64'd0);
    bcast(0, 6'd13);
    bcast(1, 6'd12);
    tick(); clear_in(); #1;
    check("dual_ready",   64'(issue_valid), 64'd1);
    issue_one();

    // pd=0 broadcast never wakes
    enq_one(mk(6'd0, 6'd4, 1'b0, 1'b1, 32'h300));
    bcast(0, 6'd0);
    bcast(1, 6'd0);
    tick(); clear_in(); #1;
    check("pd0_issue_valid", 64'(issue_valid), 64'd0);
    check("pd0_count",       64'(count),       64'd1);
    flush = 1'b1;
    #1;
    check("flush_enq_ready", 64'(enq_ready), 64'd0);
    tick(); clear_in(); #1;
    check("pd0_flushed",     64'(is_empty),  64'd1);

    // Fill to full with issue held off
    enq_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      enq_entry = mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h400 + 32'(i));
      tick();
    end
    clear_in();
    #1;
    check("full_is_full",   64'(is_full),        64'd1);
    check("full_count",     64'(count),          64'd16);
    check("full_enq_ready", 64'(enq_ready),      64'd0);
    check("full_head_pc",   64'(issue_entry.pc), 64'h400);
    enq_entry   = mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h4ff);
    enq_valid   = 1'b1;
    issue_ready = 1'b1;
    #1;
    check("full_no_passthru", 64'(enq_ready), 64'd0);
    tick(); clear_in(); #1;
    check("full_count15",  64'(count),          64'd15);
    check("full_enq_rdy1", 64'(enq_ready),      64'd1);
    check("full_next_pc",  64'(issue_entry.pc), 64'h401);

    // Flush with 6 entries plus concurrent enqueue and issue
    flush = 1'b1;
    tick(); clear_in(); #1;
    for (int i = 0; i < 6; i++) enq_one(mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h500 + 32'(i)));
    check("fl_count6", 64'(count), 64'd6);
    flush       = 1'b1;
    enq_entry   = mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h5ff);
    enq_valid   = 1'b1;
    issue_ready = 1'b1;
    #1;
    check("fl_issue_valid", 64'(issue_valid), 64'd0);
    tick(); clear_in(); #1;
    check("fl_count0", 64'(count),       64'd0);
    check("fl_empty",  64'(is_empty),    64'd1);
    check("fl_noissue",64'(issue_valid), 64'd0);
    enq_one(mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h600));
    check("fl_after_count", 64'(count),          64'd1);
    check("fl_after_pc",    64'(issue_entry.pc), 64'h600);
    issue_one();

    // Simultaneous enqueue and issue keeps count
    enq_one(mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h700));
    enq_entry   = mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h701);
    enq_valid   = 1'b1;
    issue_ready = 1'b1;
    tick(); clear_in(); #1;
    check("both_count", 64'(count),          64'd1);
    check("both_pc",    64'(issue_entry.pc), 64'h701);
    issue_one();

    // 40 enqueues interleaved with issues across pointer wrap
    next_pc = 32'h1000;
    for (int i = 0; i < 8; i++) begin
      enq_entry = mk(6'd3, 6'd4, 1'b1, 1'b1, next_pc);
      enq_valid = 1'b1;
      exp_q.push_back(next_pc);
      next_pc++;
      tick();
    end
    clear_in();
    for (int i = 0; i < 24; i++) begin
      enq_entry   = mk(6'd3, 6'd4, 1'b1, 1'b1, next_pc);
      enq_valid   = 1'b1;
      issue_ready = 1'b1;
      #1;
      check("il_valid", 64'(issue_valid),    64'd1);
      check("il_order", 64'(issue_entry.pc), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      exp_q.push_back(next_pc);
      next_pc++;
      tick();
    end
    clear_in();
    #1;
    check("il_count8", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      enq_entry = mk(6'd3, 6'd4, 1'b1, 1'b1, next_pc);
      enq_valid = 1'b1;
      exp_q.push_back(next_pc);
      next_pc++;
      tick();
    end
    clear_in();
    #1;
    check("il_full", 64'(is_full), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      issue_ready = 1'b1;
      #1;
      check("drain_valid", 64'(issue_valid),    64'd1);
      check("drain_order", 64'(issue_entry.pc), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      tick();
    end
    clear_in();
    #1;
    check("drain_empty", 64'(is_empty),     64'd1);
    check("drain_sb",    64'(exp_q.size()), 64'd0);

    // Same-cycle broadcast into the entering entry
    enq_entry = mk(6'd9, 6'd3, 1'b0, 1'b1, 32'h800);
    enq_valid = 1'b1;
    bcast(1, 6'd9);
    tick(); clear_in(); #1;
`ifdef BRQ_CDB_BYPASS_EN
    check("bypass_valid", 64'(issue_valid), 64'd1);
`else
    check("bypass_valid", 64'(issue_valid), 64'd0);
`endif
    bcast(0, 6'd9);
    tick(); clear_in(); #1;
    check("bypass_late_wake", 64'(issue_valid), 64'd1);
    issue_one();

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) enq_one(mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h900 + 32'(i)));
    enq_entry   = mk(6'd1, 6'd2, 1'b1, 1'b1, 32'h9ff);
    enq_valid   = 1'b1;
    issue_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(count),    64'd0);
    check("arst_empty", 64'(is_empty), 64'd1);
    clear_in();
    tick();
    rst = 1'b0;
    #1;
    check("arst_enq_ready",   64'(enq_ready),   64'd1);
    check("arst_issue_valid", 64'(issue_valid), 64'd0);
    enq_one(mk(6'd1, 6'd2, 1'b1, 1'b1, 32'ha00));
    check("arst_post_count", 64'(count),          64'd1);
    check("arst_post_pc",    64'(issue_entry.pc), 64'ha00);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
